core_ifetch: RTL and testbench

Instruction fetch stage of the multi-cycle RV32I core, directly upstream of `core_idecode`. On a controller fetch strobe it reads the 32-bit word at the current PC over a valid/ready instruction-memory read interface. It then presents the word on `INSTRUCTION` with a one-cycle `FETCH_DONE` pulse, after which the controller asserts `C_DECODE`. It owns the PC register and flags misaligned or bus-error fetches.

---
 rtl/core_ifetch_pkg.sv | 14 +
 rtl/core_ifetch.sv | 109 ++++++++++
 tb/tb_core_ifetch.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/core_ifetch_pkg.sv
// Shared constants and state encoding for the RV32I instruction fetch stage.
package core_ifetch_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2,
    IF_DONE = 2'd3
  } if_state_e;

endpackage

// File: rtl/core_ifetch.sv
// Instruction fetch stage: owns the PC and reads one word per controller strobe
// over a valid/ready memory read interface, flagging misaligned or errored fetches.
module core_ifetch
  import core_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        NRST,
  input  logic        C_FETCH,
  input  logic        PC_LOAD,
  input  logic [31:0] PC_NEXT,
  output logic [31:0] PC,
  output logic [31:0] PC_PLUS4,
  output logic [31:0] INSTRUCTION,
  output logic        FETCH_DONE,
  output logic        FETCH_ERR,
  output logic        IMEM_ARVALID,
  input  logic        IMEM_ARREADY,
  output logic [31:0] IMEM_ARADDR,
  input  logic        IMEM_RVALID,
  output logic        IMEM_RREADY,
  input  logic [31:0] IMEM_RDATA,
  input  logic        IMEM_RRESP
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  // State, PC and fetched-word registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= INSTR_NOP;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; controller strobes are only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      IF_IDLE: begin
        if (PC_LOAD) begin
          pc_d = PC_NEXT;
        end else if (C_FETCH) begin
          if (pc_q[1:0] == 2'b00) begin
            state_d = IF_REQ;
          end else begin
            // Misaligned PC: answer locally without touching the bus.
            state_d = IF_DONE;
            instr_d = INSTR_NOP;
            err_d   = 1'b1;
          end
        end else begin
          state_d = IF_IDLE;
        end
      end
      IF_REQ: begin
        if (IMEM_ARREADY) begin
          state_d = IF_WAIT;
        end else begin
          state_d = IF_REQ;
        end
      end
      IF_WAIT: begin
        if (IMEM_RVALID) begin
          state_d = IF_DONE;
          if (IMEM_RRESP) begin
            instr_d = INSTR_NOP;
            err_d   = 1'b1;
          end else begin
            instr_d = IMEM_RDATA;
            err_d   = 1'b0;
          end
        end else begin
          state_d = IF_WAIT;
        end
      end
      IF_DONE: begin
        state_d = IF_IDLE;
      end
      default: begin
        state_d = IF_IDLE;
      end
    endcase
  end

  assign PC           = pc_q;
  assign PC_PLUS4     = pc_q + 32'd4;
  assign IMEM_ARADDR  = pc_q;
  assign IMEM_ARVALID = (state_q == IF_REQ);
  assign IMEM_RREADY  = (state_q == IF_WAIT);
  assign FETCH_DONE   = (state_q == IF_DONE);
  assign INSTRUCTION  = instr_q;
  assign FETCH_ERR    = err_q;

endmodule

// File: tb/tb_core_ifetch.sv
// Self-checking bench for core_ifetch: directed scenarios then randomized fetches
// checked against a transaction-level model of PC, instruction and error flag.
module tb_core_ifetch;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        NRST;
  logic        C_FETCH, PC_LOAD;
  logic [31:0] PC_NEXT;
  logic [31:0] PC, PC_PLUS4, INSTRUCTION, IMEM_ARADDR;
  logic        FETCH_DONE, FETCH_ERR, IMEM_ARVALID, IMEM_RREADY;
  logic        IMEM_ARREADY, IMEM_RVALID, IMEM_RRESP;
  logic [31:0] IMEM_RDATA;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] pc_m, instr_m;
  logic        err_m;

  always #5 CLK = ~CLK;

  core_ifetch dut (
    .CLK(CLK), .NRST(NRST), .C_FETCH(C_FETCH), .PC_LOAD(PC_LOAD), .PC_NEXT(PC_NEXT),
    .PC(PC), .PC_PLUS4(PC_PLUS4), .INSTRUCTION(INSTRUCTION), .FETCH_DONE(FETCH_DONE),
    .FETCH_ERR(FETCH_ERR), .IMEM_ARVALID(IMEM_ARVALID), .IMEM_ARREADY(IMEM_ARREADY),
    .IMEM_ARADDR(IMEM_ARADDR), .IMEM_RVALID(IMEM_RVALID), .IMEM_RREADY(IMEM_RREADY),
    .IMEM_RDATA(IMEM_RDATA), .IMEM_RRESP(IMEM_RRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet_inputs();
    C_FETCH = 1'b0; PC_LOAD = 1'b0; PC_NEXT = $urandom;
    IMEM_ARREADY = 1'b0; IMEM_RVALID = 1'b0; IMEM_RRESP = 1'b0; IMEM_RDATA = $urandom;
  endtask

  task automatic noise_ctl();
    C_FETCH = 1'($urandom_range(0, 1));
    PC_LOAD = 1'($urandom_range(0, 1));
    PC_NEXT = $urandom;
  endtask

  task automatic check_held(input string tag);
    chk({tag, "_pc"}, PC, pc_m);
    chk({tag, "_instr"}, INSTRUCTION, instr_m);
    chk({tag, "_err"}, {31'd0, FETCH_ERR}, {31'd0, err_m});
  endtask

  // Load a PC in IDLE; a simultaneous C_FETCH must be dropped.
  task automatic load_pc(input logic [31:0] v);
    PC_LOAD = 1'b1; PC_NEXT = v; C_FETCH = 1'($urandom_range(0, 1));
    tick();
    quiet_inputs();
    pc_m = v;
    check_held("load");
    chk("load_plus4", PC_PLUS4, pc_m + 32'd4);
    chk("load_arvalid", {31'd0, IMEM_ARVALID}, 32'd0);
    chk("load_done", {31'd0, FETCH_DONE}, 32'd0);
  endtask

  // One fetch transaction with given address/data stalls; noise on ignored inputs.
  task automatic fetch(input int ar_st, input int r_st, input logic [31:0] rdata, input logic rresp);
    C_FETCH = 1'b1; PC_LOAD = 1'b0;
    tick();
    quiet_inputs();
    if (pc_m[1:0] != 2'b00) begin
      instr_m = NOP; err_m = 1'b1;
    end else begin
      for (int k = 0; k <= ar_st; k++) begin
        chk("req_arvalid", {31'd0, IMEM_ARVALID}, 32'd1);
        chk("req_araddr", IMEM_ARADDR, pc_m);
        chk("req_rready", {31'd0, IMEM_RREADY}, 32'd0);
        chk("req_done", {31'd0, FETCH_DONE}, 32'd0);
        noise_ctl();
        IMEM_RVALID = 1'($urandom_range(0, 1)); IMEM_RDATA = $urandom;
        IMEM_RRESP = 1'($urandom_range(0, 1));
        IMEM_ARREADY = (k == ar_st);
        tick();
      end
      IMEM_ARREADY = 1'b0;
      for (int k = 0; k <= r_st; k++) begin
        chk("wait_rready", {31'd0, IMEM_RREADY}, 32'd1);
        chk("wait_arvalid", {31'd0, IMEM_ARVALID}, 32'd0);
        chk("wait_done", {31'd0, FETCH_DONE}, 32'd0);
        noise_ctl();
        IMEM_RVALID = (k == r_st);
        IMEM_RDATA  = (k == r_st) ? rdata : $urandom;
        IMEM_RRESP  = (k == r_st) ? rresp : 1'($urandom_range(0, 1));
        tick();
      end
      quiet_inputs();
      instr_m = rresp ? NOP : rdata;
      err_m   = rresp;
    end
    chk("done_pulse", {31'd0, FETCH_DONE}, 32'd1);
    chk("done_arvalid", {31'd0, IMEM_ARVALID}, 32'd0);
    check_held("done");
    noise_ctl();
    IMEM_RVALID = 1'($urandom_range(0, 1));
    tick();
    quiet_inputs();
    chk("after_done", {31'd0, FETCH_DONE}, 32'd0);
    check_held("after");
  endtask

  initial begin
    quiet_inputs();
    NRST = 1'b0;
    tick();
    tick();
    pc_m = RST_PC; instr_m = NOP; err_m = 1'b0;
    check_held("reset");
    chk("reset_done", {31'd0, FETCH_DONE}, 32'd0);
    chk("reset_arvalid", {31'd0, IMEM_ARVALID}, 32'd0);
    chk("reset_rready", {31'd0, IMEM_RREADY}, 32'd0);
    NRST = 1'b1;
    tick();

    fetch(0, 0, 32'h0050_0093, 1'b0);
    load_pc(32'h0000_0100);
    fetch(3, 2, 32'h1234_5678, 1'b0);
    load_pc(32'h0000_0102);
    fetch(0, 0, 32'hDEAD_BEEF, 1'b0);
    load_pc(32'h0000_0104);
    fetch(1, 0, 32'hFFFF_FFFF, 1'b1);
    load_pc(32'h0000_0108);
    fetch(0, 1, 32'h0000_0513, 1'b0);

    // Spurious read data while idle must be ignored.
    for (int k = 0; k < 3; k++) begin
      IMEM_RVALID = 1'b1; IMEM_RDATA = $urandom; IMEM_RRESP = 1'($urandom_range(0, 1));
      tick();
      chk("idle_rvalid_done", {31'd0, FETCH_DONE}, 32'd0);
      check_held("idle_rvalid");
    end
    quiet_inputs();

    load_pc(32'hFFFF_FFFC);
    chk("wrap_plus4", PC_PLUS4, 32'h0000_0000);

    // Reset in the middle of a request.
    load_pc(32'h0000_0200);
    C_FETCH = 1'b1;
    tick();
    C_FETCH = 1'b0;
    chk("rst_req_arvalid", {31'd0, IMEM_ARVALID}, 32'd1);
    NRST = 1'b0;
    tick();
    NRST = 1'b1;
    pc_m = RST_PC; instr_m = NOP; err_m = 1'b0;
    chk("rst_mid_arvalid", {31'd0, IMEM_ARVALID}, 32'd0);
    chk("rst_mid_done", {31'd0, FETCH_DONE}, 32'd0);
    check_held("rst_mid");
    tick();
    chk("rst_after_done", {31'd0, FETCH_DONE}, 32'd0);
    chk("rst_after_arvalid", {31'd0, IMEM_ARVALID}, 32'd0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] v;
      v = $urandom;
      if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
      load_pc(v);
      fetch(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), $urandom,
            ($urandom_range(0, 4) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
